// File: rtl/csr_unit.sv
// Zicsr CSR unit: general-purpose CSR window, 64-bit mcycle/minstret with RO shadows,
// mhartid, atomic RW/RS/RC read-modify-write and illegal-access detection.
module csr_unit #(
   parameter int              XLEN         = 32,
   parameter int              CSR_ADDR_LEN = 4,
   parameter logic [11:0]     BASE_ADDR    = 12'h340,
   parameter logic [XLEN-1:0] MHARTID      = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                csr_en,
   input  logic [2:0]          csr_op,
   input  logic [11:0]         csr_addr,
   input  logic [XLEN-1:0]     csr_src,
   input  logic [4:0]          csr_zimm,
   input  logic                csr_src_zero,
   input  logic                instret_inc,
   output logic [XLEN-1:0]     csr_rdata,
   output logic                csr_illegal
);

   // Handshake: csr_en is a valid with no ready; an enabled op is always accepted in the
   // cycle it is presented, and its write (if legal) lands on the next rising clk edge.

   localparam int NGEN = 2 ** CSR_ADDR_LEN;
   localparam int CW   = 2 * XLEN;

   logic [XLEN-1:0]         gen_q [NGEN];
   logic [CW-1:0]           mcycle_q, minstret_q;
   logic [CW-1:0]           mcycle_d, minstret_d;
   logic [CSR_ADDR_LEN-1:0] gen_idx;
   logic                    sel_gen, mapped, ro_addr, op_valid, imm_form;
   logic                    write_intent, do_write;
   logic                    wr_gen, wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
   logic [XLEN-1:0]         operand, new_val;

   assign gen_idx  = csr_addr[CSR_ADDR_LEN-1:0];
   assign sel_gen  = (csr_addr[11:CSR_ADDR_LEN] == BASE_ADDR[11:CSR_ADDR_LEN]);
   assign ro_addr  = (csr_addr[11:10] == 2'b11);
   assign op_valid = (csr_op[1:0] != 2'b00);
   assign imm_form = csr_op[2];
   assign operand  = imm_form ? {{(XLEN-5){1'b0}}, csr_zimm} : csr_src;

   // Read mux; the shadows alias the machine counters, so a read never sees a pending write.
   always_comb begin
      csr_rdata = '0;
      mapped    = 1'b1;
      if (sel_gen) begin
         csr_rdata = gen_q[gen_idx];
      end else begin
         case (csr_addr)
            12'hB00, 12'hC00: csr_rdata = mcycle_q[XLEN-1:0];
            12'hB80, 12'hC80: csr_rdata = mcycle_q[CW-1:XLEN];
            12'hB02, 12'hC02: csr_rdata = minstret_q[XLEN-1:0];
            12'hB82, 12'hC82: csr_rdata = minstret_q[CW-1:XLEN];
            12'hF14:          csr_rdata = MHARTID;
            default:          mapped    = 1'b0;
         endcase
      end
   end

   // RS/RC with a zero source are pure reads, which is what lets them touch RO CSRs.
   always_comb begin
      write_intent = 1'b0;
      new_val      = csr_rdata;
      case (csr_op[1:0])
         2'b01: begin
            write_intent = 1'b1;
            new_val      = operand;
         end
         2'b10: begin
            write_intent = imm_form ? (csr_zimm != 5'd0) : !csr_src_zero;
            new_val      = csr_rdata | operand;
         end
         2'b11: begin
            write_intent = imm_form ? (csr_zimm != 5'd0) : !csr_src_zero;
            new_val      = csr_rdata & ~operand;
         end
         default: begin
            write_intent = 1'b0;
            new_val      = csr_rdata;
         end
      endcase
   end

   assign csr_illegal = csr_en && (!mapped || !op_valid || (write_intent && ro_addr));
   assign do_write    = csr_en && !csr_illegal && write_intent;

   assign wr_gen    = do_write && sel_gen;
   assign wr_cyc_lo = do_write && !sel_gen && (csr_addr == 12'hB00);
   assign wr_cyc_hi = do_write && !sel_gen && (csr_addr == 12'hB80);
   assign wr_ins_lo = do_write && !sel_gen && (csr_addr == 12'hB02);
   assign wr_ins_hi = do_write && !sel_gen && (csr_addr == 12'hB82);

   // A half-write replaces the increment for that counter in this cycle.
   always_comb begin
      mcycle_d   = mcycle_q + CW'(1);
      minstret_d = instret_inc ? (minstret_q + CW'(1)) : minstret_q;
      if (wr_cyc_lo) mcycle_d   = {mcycle_q[CW-1:XLEN], new_val};
      if (wr_cyc_hi) mcycle_d   = {new_val, mcycle_q[XLEN-1:0]};
      if (wr_ins_lo) minstret_d = {minstret_q[CW-1:XLEN], new_val};
      if (wr_ins_hi) minstret_d = {new_val, minstret_q[XLEN-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NGEN; i++) gen_q[i] <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (wr_gen) gen_q[gen_idx] <= new_val;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

endmodule
